buffer_fifo: RTL

Parametrised, registered successor to the single-bit buffer gate: a WIDTH-bit, DEPTH-entry first-word-fall-through buffer with valid/ready handshakes on both sides. It decouples a producer from a consumer that may stall, and sits on any datapath where the plain combinational buffer is no longer enough. An optional bypass path restores zero-latency pass-through when the buffer is empty.

---
 rtl/buffer_pkg.sv | 12 +
 rtl/buffer_fifo_mem.sv | 18 +
 rtl/buffer_fifo.sv | 69 ++++++
 3 files changed

// File: rtl/buffer_pkg.sv
// buffer_pkg: shared defaults, clog2 helper and count width for buffer blocks.
package buffer_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  localparam int CNT_W = clog2(DEPTH_DEF + 1);
endpackage

// File: rtl/buffer_fifo_mem.sv
// buffer_fifo_mem: DEPTH x WIDTH register array, one write port, async read, no reset.
module buffer_fifo_mem
  import buffer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [clog2(DEPTH)-1:0]  waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [clog2(DEPTH)-1:0]  raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/buffer_fifo.sv
// buffer_fifo: WIDTH x DEPTH first-word-fall-through FIFO with valid/ready on both sides.
// Define BUFFER_FIFO_BYPASS_EN for zero-latency pass-through while empty.
module buffer_fifo
  import buffer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           b,
  output logic [clog2(DEPTH+1)-1:0]  count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [WIDTH-1:0] rdata;
  logic byp, push, pop, we, rd;
  buffer_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (a),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );
  always_comb begin
    empty = count_q == '0;
    full = count_q == CW'(DEPTH);
    in_ready = !full;
`ifdef BUFFER_FIFO_BYPASS_EN
    byp = empty && in_valid;
    out_valid = !empty || byp;
    b = byp ? a : (empty ? '0 : rdata);
`else
    byp = 1'b0;
    out_valid = !empty;
    b = empty ? '0 : rdata;
`endif
    push = in_valid && in_ready;
    pop = out_valid && out_ready;
    // a bypassed word that is consumed in the same cycle never touches storage
    we = push && !(byp && out_ready);
    rd = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(we);
    rd_ptr_d = rd_ptr_q + AW'(rd);
    count_d = count_q + CW'(we) - CW'(rd);
    count = count_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
endmodule
